// File: rtl/bus_sequencer_if.sv
// bus_sequencer_if: command/strobe bundle of bus_sequencer; abort/aborted exist only with BUS_SEQUENCER_ABORT_EN
interface bus_sequencer_if #(parameter int CNT_W = 4);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             RAin, RBin, RZin;
    logic             RAout, RBout, RZout;
    logic [1:0]       tstate;
`ifdef BUS_SEQUENCER_ABORT_EN
    logic             abort;
    logic             aborted;
    modport master (output start, op, count, abort,
                    input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout, tstate, aborted);
    modport slave  (input  start, op, count, abort,
                    output busy, done, RAin, RBin, RZin, RAout, RBout, RZout, tstate, aborted);
`else
    modport master (output start, op, count,
                    input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout, tstate);
    modport slave  (input  start, op, count,
                    output busy, done, RAin, RBin, RZin, RAout, RBout, RZout, tstate);
`endif
endinterface

// File: rtl/bus_sequencer.sv
// bus_sequencer: Moore T-state controller driving RA/RB/RZ load and bus-drive strobes.
// Optional abort input/aborted output enabled by defining BUS_SEQUENCER_ABORT_EN.
module bus_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic          clock,
    input  logic          clear,
    bus_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, T1, T2, DONE} state_t;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_MOVE = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_ACC  = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       str_q, str_d, t1_str;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       tst_q, tst_d;
    logic             abort_s;

`ifdef BUS_SEQUENCER_ABORT_EN
    logic abt_q, abt_d;
    assign abort_s     = bus.abort;
    assign abt_d       = abort_s && (state_q == T1 || state_q == T2);
    assign bus.aborted = abt_q;
    // aborted flag marks the DONE cycle reached through an abort
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) abt_q <= 1'b0;
        else        abt_q <= abt_d;
    end
`else
    assign abort_s = 1'b0;
`endif

    // next state, command latch and decode of the registered outputs from the next state
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                op_d    = bus.op;
                cnt_d   = bus.count;
                state_d = (bus.op == OP_ACC && bus.count == '0) ? DONE : T1;
            end
            T1: state_d = (abort_s || op_q == OP_LOAD || op_q == OP_MOVE) ? DONE : T2;
            T2: begin
                cnt_d   = (op_q == OP_ACC) ? cnt_q - CNT_W'(1) : cnt_q;
                state_d = (!abort_s && op_q == OP_ACC && cnt_q != CNT_W'(1)) ? T1 : DONE;
            end
            default: state_d = IDLE;
        endcase
        // strobe order {RAin, RBin, RZin, RAout, RBout, RZout}
        t1_str = (op_d == OP_LOAD) ? 6'b100000 :
                 (op_d == OP_MOVE) ? 6'b010100 :
                 (op_d == OP_ADD)  ? 6'b001100 : 6'b001010;
        str_d  = (state_d == T1) ? t1_str : (state_d == T2) ? 6'b010001 : 6'b000000;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        tst_d  = (state_d == T1) ? 2'd1 : (state_d == T2) ? 2'd2 : 2'd0;
    end

    // state, latched command and all outputs update together on the same edge
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            cnt_q   <= '0;
            str_q   <= 6'b000000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tst_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            str_q   <= str_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tst_q   <= tst_d;
        end
    end

    assign {bus.RAin, bus.RBin, bus.RZin, bus.RAout, bus.RBout, bus.RZout} = str_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.tstate = tst_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: table-driven and randomized check of bus_sequencer against a datapath and arithmetic model
module tb_bus_sequencer;
    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] a_val = 8'h05;
    logic [7:0] imm   = 8'h03;
    logic [7:0] ra = 8'h00, rb = 8'h00, rz = 8'h00;
    logic [7:0] mra = 8'h00, mrb = 8'h00;
    logic [7:0] dbus;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        int         noise;
        int         lat;
        logic [7:0] ra;
        logic [7:0] rb;
    } vec_t;
    vec_t vt[7];

    bus_sequencer_if #(.CNT_W(4)) bus();
    bus_sequencer #(.CNT_W(4)) dut (.clock(clock), .clear(clear), .bus(bus));

    always #5 clock = ~clock;

    assign dbus = bus.RAout ? ra : bus.RBout ? rb : bus.RZout ? rz : 8'h00;
    always @(posedge clock) begin
        if (bus.RAin) ra <= imm;
        if (bus.RBin) rb <= dbus;
        if (bus.RZin) rz <= a_val + dbus;
    end

    function automatic logic [9:0] outv();
        return {bus.busy, bus.done, bus.tstate, bus.RAin, bus.RBin, bus.RZin, bus.RAout, bus.RBout, bus.RZout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input int noise, input int exp_lat);
        logic [9:0] exp_q[$];
        logic [9:0] act;
        int         cyc;
        bit         got;
        case (op)
            2'd0: exp_q.push_back({2'b10, 2'd1, 6'b100000});
            2'd1: exp_q.push_back({2'b10, 2'd1, 6'b010100});
            2'd2: begin
                exp_q.push_back({2'b10, 2'd1, 6'b001100});
                exp_q.push_back({2'b10, 2'd2, 6'b010001});
            end
            default: for (int i = 0; i < int'(cnt); i++) begin
                exp_q.push_back({2'b10, 2'd1, 6'b001010});
                exp_q.push_back({2'b10, 2'd2, 6'b010001});
            end
        endcase
        exp_q.push_back({2'b11, 2'd0, 6'b000000});
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.count = cnt;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            act = outv();
            chk("trace", 32'(act), cyc <= exp_q.size() ? 32'(exp_q[cyc-1]) : 32'h3ff);
            chk("one_driver", 32'($countones(act[2:0]) <= 1), 32'd1);
            chk("no_self_load", 32'(|(act[5:3] & act[2:0])), 32'd0);
            got = act[8];
`ifdef BUS_SEQUENCER_ABORT_EN
            if (got) chk("aborted_clear", 32'(bus.aborted), 32'd0);
`endif
            @(negedge clock);
            bus.start = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.op    = (noise == 2) ? 2'd1 : 2'($urandom);
            bus.count = 4'($urandom);
        end
        chk("latency", 32'(cyc), 32'(exp_q.size()));
        if (exp_lat >= 0) chk("lat_table", 32'(cyc), 32'(exp_lat));
        @(posedge clock);
        #1;
        chk("idle_after", 32'(outv()), 32'd0);
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] cnt, input int noise, input int exp_lat);
        run_cmd(op, cnt, noise, exp_lat);
        case (op)
            2'd0: mra = imm;
            2'd1: mrb = mra;
            2'd2: mrb = 8'(a_val + mra);
            default: mrb = 8'(int'(mrb) + int'(cnt) * int'(a_val));
        endcase
        chk("RA", 32'(ra), 32'(mra));
        chk("RB", 32'(rb), 32'(mrb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{2'd0, 4'd0,  0, 2,  8'h03, 8'h00};
        vt[1] = '{2'd2, 4'd0,  2, 3,  8'h03, 8'h08};
        vt[2] = '{2'd3, 4'd3,  0, 7,  8'h03, 8'h17};
        vt[3] = '{2'd3, 4'd0,  0, 1,  8'h03, 8'h17};
        vt[4] = '{2'd1, 4'd0,  1, 2,  8'h03, 8'h03};
        vt[5] = '{2'd3, 4'd15, 1, 31, 8'h03, 8'h4E};
        vt[6] = '{2'd2, 4'd9,  0, 3,  8'h03, 8'h08};
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.count = 4'd0;
`ifdef BUS_SEQUENCER_ABORT_EN
        bus.abort = 1'b0;
`endif
        #1 clear = 1'b0;
        #1 chk("reset_async", 32'(outv()), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock) clear = 1'b1;
        @(posedge clock);
        #1 chk("reset_idle", 32'(outv()), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_cmd(vt[i].op, vt[i].cnt, vt[i].noise, vt[i].lat);
            chk("tab_RA", 32'(ra), 32'(vt[i].ra));
            chk("tab_RB", 32'(rb), 32'(vt[i].rb));
        end

        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.count = 4'd5;
        @(posedge clock);
        #1 chk("racc_t1", 32'(outv()), 32'({2'b10, 2'd1, 6'b001010}));
        @(negedge clock) bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1 chk("racc_t2b", 32'(outv()), 32'({2'b10, 2'd2, 6'b010001}));
        #2 clear = 1'b0;
        #1 chk("racc_async", 32'(outv()), 32'd0);
        repeat (2) @(posedge clock);
        #1 chk("racc_hold", 32'(outv()), 32'd0);
        @(negedge clock) clear = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1 chk("racc_post", 32'(outv()), 32'd0);
        end
        mrb = 8'(mrb + a_val);
        chk("racc_RB", 32'(rb), 32'(mrb));

`ifdef BUS_SEQUENCER_ABORT_EN
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.count = 4'd4;
        @(posedge clock);
        @(negedge clock) bus.start = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk("abort_t1b", 32'(outv()), 32'({2'b10, 2'd1, 6'b001010}));
        @(negedge clock) bus.abort = 1'b1;
        @(posedge clock);
        #1 chk("abort_done", 32'(outv()), 32'({2'b11, 2'd0, 6'b000000}));
        chk("abort_flag", 32'(bus.aborted), 32'd1);
        @(negedge clock) bus.abort = 1'b0;
        @(posedge clock);
        #1 chk("abort_idle", 32'({outv(), bus.aborted}), 32'd0);
        mrb = 8'(mrb + a_val);
        chk("abort_RB", 32'(rb), 32'(mrb));
`endif

        for (int i = 0; i < 40; i++) begin
            a_val = 8'($urandom);
            imm   = 8'($urandom);
            do_cmd(2'($urandom), ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
